// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl_pkg
// Brief    : Shared widths, exception bit indices, NOP encoding and fetch
//            FSM state encoding for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_ctrl_pkg;

  // Default datapath widths (REG_BUS / EXCP_BUS)
  localparam int DEF_XLEN   = 64;
  localparam int DEF_INST_W = 32;
  localparam int DEF_EXCP_W = 16;

  // Instruction substituted when a fetch faults (addi x0, x0, 0)
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  // Exception vector bit positions
  localparam int EXCP_INST_MISAL     = 0;
  localparam int EXCP_INST_ACC_FAULT = 1;

  // Fetch FSM state encoding
  localparam int              ST_W     = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_DRAIN = ST_DRAIN
  } fetch_state_e;

  typedef logic [DEF_XLEN-1:0]   reg_bus_t;
  typedef logic [DEF_EXCP_W-1:0] excp_bus_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl_if
// Brief    : Instruction-memory port and decode-stage handshake bundle of the
//            fetch controller. master = fetch controller, slave = environment
//            (memory + decode).
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_ctrl_if
  import ifetch_ctrl_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int INST_W = DEF_INST_W,
  parameter int EXCP_W = DEF_EXCP_W
) ();

  // Instruction memory request / response
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              imem_resp_err;

  // Decode-stage handshake
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [EXCP_W-1:0] id_excp;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    output id_valid, id_pc, id_inst, id_excp,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    input  id_valid, id_pc, id_inst, id_excp,
    output id_ready
  );

endinterface
`default_nettype wire

// File: rtl/ifetch_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_out_reg
// Brief    : Decode-facing output register {pc, inst, excp, valid}. Loaded on
//            entry to HOLD, valid drops on handshake, everything clears on
//            clear (redirect) or reset.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_out_reg
  import ifetch_ctrl_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int INST_W = DEF_INST_W,
  parameter int EXCP_W = DEF_EXCP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              ready_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [EXCP_W-1:0] excp_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [EXCP_W-1:0] excp_o
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic [EXCP_W-1:0] excp_q;

  // Payload only changes on load; after a handshake it keeps its last value.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      excp_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      excp_q  <= excp_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign excp_o  = excp_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : Single-outstanding instruction fetch controller between the PC
//            generator and decode. Issues one imem request per PC, registers
//            the response and hands {pc, inst, excp} to decode; redirects
//            (flush) discard in-flight fetches via a DRAIN state.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int          XLEN     = DEF_XLEN,
  parameter int          INST_W   = DEF_INST_W,
  parameter int          EXCP_W   = DEF_EXCP_W,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [EXCP_W-1:0] pc_excp_i,
  output logic              pc_advance,
  input  logic              flush,
  ifetch_ctrl_if.master     bus
);

  fetch_state_e      state_q;
  logic [XLEN-1:0]   fpc_q;
  logic [EXCP_W-1:0] fexcp_q;
  logic              req_valid_q;
  logic [XLEN-1:0]   req_addr_q;

  logic              out_load;
  logic [XLEN-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [EXCP_W-1:0] out_excp;

  logic              id_valid_w;
  logic [XLEN-1:0]   id_pc_w;
  logic [INST_W-1:0] id_inst_w;
  logic [EXCP_W-1:0] id_excp_w;

  logic              req_hs;

  assign req_hs = req_valid_q && bus.imem_req_ready;

  // Fetch FSM with registered request outputs; flush overrides normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fpc_q       <= '0;
      fexcp_q     <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else if (flush) begin
      req_valid_q <= 1'b0;
      unique case (state_q)
        // An accepted request still owes a response, so it must be drained.
        S_REQ:   state_q <= req_hs ? S_DRAIN : S_IDLE;
        S_WAIT:  state_q <= bus.imem_resp_valid ? S_IDLE : S_DRAIN;
        // Drain keeps waiting for its one response; if it arrives now it is
        // the discarded one and nothing remains outstanding.
        S_DRAIN: state_q <= bus.imem_resp_valid ? S_IDLE : S_DRAIN;
        default: state_q <= S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          fpc_q   <= pc_i;
          fexcp_q <= pc_excp_i;
          if (pc_excp_i != '0) begin
            // Faulting PC: no memory access, NOP goes straight to decode.
            state_q <= S_HOLD;
          end else begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_i;
          end
        end
        S_REQ: begin
          if (bus.imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.id_ready) state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.imem_resp_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Select what the output register captures on entry to HOLD.
  always_comb begin
    out_load = 1'b0;
    out_pc   = fpc_q;
    out_inst = bus.imem_resp_err ? NOP_INST[INST_W-1:0] : bus.imem_resp_data;
    out_excp = fexcp_q;
    out_excp[EXCP_INST_ACC_FAULT] = fexcp_q[EXCP_INST_ACC_FAULT] | bus.imem_resp_err;
    if (!flush) begin
      unique case (state_q)
        S_IDLE: begin
          if (pc_excp_i != '0) begin
            out_load = 1'b1;
            out_pc   = pc_i;
            out_inst = NOP_INST[INST_W-1:0];
            out_excp = pc_excp_i;
          end
        end
        S_WAIT:  out_load = bus.imem_resp_valid;
        default: out_load = 1'b0;
      endcase
    end
  end

  ifetch_out_reg #(
    .XLEN   (XLEN),
    .INST_W (INST_W),
    .EXCP_W (EXCP_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .clear_i (flush),
    .ready_i (bus.id_ready),
    .pc_i    (out_pc),
    .inst_i  (out_inst),
    .excp_i  (out_excp),
    .valid_o (id_valid_w),
    .pc_o    (id_pc_w),
    .inst_o  (id_inst_w),
    .excp_o  (id_excp_w)
  );

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.id_valid       = id_valid_w;
  assign bus.id_pc          = id_pc_w;
  assign bus.id_inst        = id_inst_w;
  assign bus.id_excp        = id_excp_w;

  // The PC steps only on an accepted, non-redirected decode handshake.
  assign pc_advance = !rst && !flush && (state_q == S_HOLD) && id_valid_w && bus.id_ready;

  // Only one request is ever in flight, so responses are legal only while
  // waiting for or draining that request.
  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_resp_valid |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_ctrl
// Brief    : Self-checking bench for ifetch_ctrl: directed scenarios followed
//            by randomized memory/decode/redirect traffic, all compared with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  localparam logic [31:0] NOP = DEF_NOP_INST;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic [15:0] pc_excp_i;
  logic        pc_advance;
  logic        flush;

  always #5 clk = ~clk;

  ifetch_ctrl_if bus ();

  ifetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .pc_excp_i  (pc_excp_i),
    .pc_advance (pc_advance),
    .flush      (flush),
    .bus        (bus)
  );

  int n_test = 0;
  int n_fail = 0;

  // Reference model: what the controller owes the outside world.
  bit          m_settle;    // a PC sample is due at the end of this cycle
  bit          m_req;       // a request is being presented
  bit          m_inflight;  // an accepted request still owes a response
  bit          m_drop;      // that response belongs to a redirected fetch
  bit          m_hold;      // an instruction is presented to decode
  logic [63:0] m_addr;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [15:0] m_excp;

  // PC generator model
  logic [63:0] tb_pc;
  bit          exp_adv;

  // Memory model
  bit mem_busy;
  int mem_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
    if ($urandom_range(0, 4) == 0) t[1] = 1'b1;
    return t;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance it.
  task automatic step(input bit fl, input bit rrdy, input bit rv,
                      input logic [31:0] rd, input bit re, input bit irdy);
    bit acc;
    @(negedge clk);
    rst                 = 1'b0;
    flush               = fl;
    pc_i                = tb_pc;
    pc_excp_i           = {15'b0, tb_pc[1]};
    bus.imem_req_ready  = rrdy;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rd;
    bus.imem_resp_err   = re;
    bus.id_ready        = irdy;
    #1;
    exp_adv = m_hold && irdy && !fl;
    chk("pc_advance", 64'(pc_advance), 64'(exp_adv));
    chk("req_valid", 64'(bus.imem_req_valid), 64'(m_req));
    if (m_req) chk("req_addr", bus.imem_req_addr, m_addr);
    chk("id_valid", 64'(bus.id_valid), 64'(m_hold));
    chk("id_pc", bus.id_pc, m_pc);
    chk("id_inst", 64'(bus.id_inst), 64'(m_inst));
    chk("id_excp", 64'(bus.id_excp), 64'(m_excp));

    if (fl) begin
      acc    = m_req && rrdy;
      m_hold = 1'b0;
      m_pc   = '0;
      m_inst = '0;
      m_excp = '0;
      m_req  = 1'b0;
      if (acc) m_inflight = 1'b1;
      else if (m_inflight && rv) m_inflight = 1'b0;
      if (m_inflight) m_drop = 1'b1;
      m_settle = !m_inflight;
    end else if (m_settle) begin
      m_settle = 1'b0;
      if (pc_excp_i != 16'h0) begin
        m_hold = 1'b1;
        m_pc   = pc_i;
        m_inst = NOP;
        m_excp = pc_excp_i;
      end else begin
        m_req  = 1'b1;
        m_addr = pc_i;
      end
    end else if (m_req) begin
      if (rrdy) begin
        m_req      = 1'b0;
        m_inflight = 1'b1;
        m_drop     = 1'b0;
      end
    end else if (m_inflight) begin
      if (rv) begin
        m_inflight = 1'b0;
        if (m_drop) begin
          m_settle = 1'b1;
        end else begin
          m_hold = 1'b1;
          m_pc   = m_addr;
          m_inst = re ? NOP : rd;
          m_excp = re ? (16'h1 << EXCP_INST_ACC_FAULT) : 16'h0;
        end
      end
    end else if (m_hold) begin
      if (irdy) begin
        m_hold   = 1'b0;
        m_settle = 1'b1;
      end
    end

    if (fl) tb_pc = rand_target();
    else if (exp_adv) tb_pc = tb_pc + 64'd4;
  endtask

  initial begin
    rst                 = 1'b1;
    flush               = 1'b0;
    pc_i                = 64'h1234;
    pc_excp_i           = 16'h0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    bus.id_ready        = 1'b1;
    mem_busy            = 1'b0;
    mem_wait            = 0;

    // ---- Reset values (reset held while id_ready is high) ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_advance", 64'(pc_advance), 64'h0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    chk("rst_req_addr", bus.imem_req_addr, 64'h0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'h0);
    chk("rst_id_pc", bus.id_pc, 64'h0);
    chk("rst_id_inst", 64'(bus.id_inst), 64'h0);
    chk("rst_id_excp", 64'(bus.id_excp), 64'h0);

    m_settle = 1'b1; m_req = 1'b0; m_inflight = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
    m_addr = '0; m_pc = '0; m_inst = '0; m_excp = '0;
    tb_pc = 64'h8000_0000;

    // ---- Basic fetch with zero-wait memory ----
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("t1_req_valid", 64'(bus.imem_req_valid), 64'h1);
    chk("t1_req_addr", bus.imem_req_addr, 64'h8000_0000);
    step(0, 1, 1, 32'h0010_0093, 0, 0);
    chk("t1_no_valid_in_resp_cycle", 64'(bus.id_valid), 64'h0);
    step(0, 1, 0, 32'h0, 0, 1);
    chk("t1_id_valid", 64'(bus.id_valid), 64'h1);
    chk("t1_id_inst", 64'(bus.id_inst), 64'h0010_0093);
    chk("t1_id_excp", 64'(bus.id_excp), 64'h0);
    chk("t1_pc_advance", 64'(pc_advance), 64'h1);

    // ---- Memory back-pressure for 3 cycles ----
    step(0, 0, 0, 32'h0, 0, 0);
    repeat (3) begin
      step(0, 0, 0, 32'h0, 0, 0);
      chk("t2_req_held", 64'(bus.imem_req_valid), 64'h1);
      chk("t2_addr_held", bus.imem_req_addr, 64'h8000_0004);
    end
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h0020_8113, 0, 0);
    chk("t2_no_early_valid", 64'(bus.id_valid), 64'h0);
    step(0, 0, 0, 32'h0, 0, 1);
    chk("t2_id_pc", bus.id_pc, 64'h8000_0004);

    // ---- Access fault on response ----
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFF, 1, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("t3_nop", 64'(bus.id_inst), 64'h0000_0013);
    chk("t3_acc_fault", 64'(bus.id_excp[EXCP_INST_ACC_FAULT]), 64'h1);
    chk("t3_pc", bus.id_pc, 64'h8000_0008);
    step(0, 1, 0, 32'h0, 0, 1);

    // ---- Misaligned PC: no memory access ----
    tb_pc = 64'h8000_0002;
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("t4_no_req", 64'(bus.imem_req_valid), 64'h0);
    chk("t4_id_valid", 64'(bus.id_valid), 64'h1);
    chk("t4_misal", 64'(bus.id_excp[EXCP_INST_MISAL]), 64'h1);
    chk("t4_nop", 64'(bus.id_inst), 64'h0000_0013);
    step(0, 1, 0, 32'h0, 0, 1);

    // ---- Flush while waiting: late response is discarded ----
    tb_pc = 64'h8000_1000;
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    step(1, 1, 0, 32'h0, 0, 0);
    tb_pc = 64'h8000_2000;
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'hDEAD_BEEF, 0, 1);
    chk("t5_discarded", 64'(bus.id_valid), 64'h0);
    step(0, 1, 0, 32'h0, 0, 1);
    step(0, 1, 0, 32'h0, 0, 1);
    chk("t5_new_addr", bus.imem_req_addr, 64'h8000_2000);
    step(0, 1, 1, 32'h0030_0193, 0, 1);
    step(0, 1, 0, 32'h0, 0, 1);
    chk("t5_inst", 64'(bus.id_inst), 64'h0030_0193);

    // ---- Decode stall in HOLD, then flush ----
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'h1234_5678, 0, 0);
    repeat (5) begin
      step(0, 1, 0, 32'h0, 0, 0);
      chk("t6_stable_valid", 64'(bus.id_valid), 64'h1);
      chk("t6_stable_inst", 64'(bus.id_inst), 64'h1234_5678);
      chk("t6_stable_pc", bus.id_pc, 64'h8000_2004);
    end
    step(1, 1, 0, 32'h0, 0, 1);
    chk("t6_no_advance_on_flush", 64'(pc_advance), 64'h0);
    step(0, 0, 0, 32'h0, 0, 0);
    chk("t6_valid_dropped", 64'(bus.id_valid), 64'h0);

    // ---- Randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      bit          rv;
      bit          re;
      bit          fl;
      bit          rrdy;
      bit          irdy;
      logic [31:0] rd;
      rv = 1'b0;
      rd = $urandom;
      re = ($urandom_range(0, 5) == 0);
      if (mem_busy) begin
        if (mem_wait == 0) begin
          rv       = 1'b1;
          mem_busy = 1'b0;
        end else begin
          mem_wait--;
        end
      end
      rrdy = ($urandom_range(0, 9) < 7);
      irdy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 11) == 0) && !(rv && m_inflight && m_drop);
      step(fl, rrdy, rv, rd, re, irdy);
      if (bus.imem_req_valid && rrdy) begin
        mem_busy = 1'b1;
        mem_wait = $urandom_range(0, 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
